// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and default sizing for the multicycle memory responder
package mem_pkg;

    localparam int DEPTH_WORDS_DEF = 256;
    localparam int WAIT_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/mem_word_array.sv
// rtl/mem_word_array.sv - word storage with synchronous write and registered synchronous read
module mem_word_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  index,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Contents survive reset; only writes while out of reset are honoured.
    always_ff @(posedge clk) begin
        if (we && rst_n) begin
            mem[index] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - multicycle memory responder FSM; MEM_ALIGN_CHECK_EN adds a misaligned-address reject
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_Read,
    input  logic              Mem_Write,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Write_Data,
    output logic [DATA_W-1:0] Read_Data,
    output logic              Mem_Ready,
    output logic              Mem_Busy,
    output logic              Mem_Error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state;
    op_t               op;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;

    logic              req;
    logic              conflict;
    logic              out_of_range;
    logic              misalign;
    logic              accept;
    logic              reject;
    logic              direct;
    logic              finish;
    logic              arr_we;
    logic              arr_re;
    logic [IDX_W-1:0]  arr_idx;
    logic [DATA_W-1:0] arr_wdata;

    assign req          = Mem_Read ^ Mem_Write;
    assign conflict     = Mem_Read & Mem_Write;
    assign out_of_range = (Address >> (IDX_W + 2)) != '0;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = Address[1:0] != 2'b00;
`else
    assign misalign = 1'b0;
`endif

    assign accept = (state == IDLE) && req && !out_of_range && !misalign;
    assign reject = (state == IDLE) && (conflict || (req && (out_of_range || misalign)));

    // With no wait cycles the access happens on the accepting edge, straight from the inputs.
    assign direct = accept && (WAIT_CYCLES == 0);
    assign finish = (state == BUSY) && (cnt == CNT_ONE);

    assign arr_we    = direct ? Mem_Write : (finish && (op == OP_WRITE));
    assign arr_re    = direct ? Mem_Read  : (finish && (op == OP_READ));
    assign arr_idx   = direct ? Address[IDX_W+1:2] : idx_q;
    assign arr_wdata = direct ? Write_Data : wdata_q;

    assign Mem_Busy = (state != IDLE);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            op        <= OP_READ;
            cnt       <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            Mem_Ready <= 1'b0;
            Mem_Error <= 1'b0;
        end else begin
            Mem_Ready <= (state == DONE);
            Mem_Error <= reject;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op      <= Mem_Write ? OP_WRITE : OP_READ;
                        idx_q   <= Address[IDX_W+1:2];
                        wdata_q <= Write_Data;
                        cnt     <= CNT_LOAD;
                        state   <= (WAIT_CYCLES > 0) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_ONE;
                    if (finish) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (Clk),
        .rst_n (Reset),
        .we    (arr_we),
        .re    (arr_re),
        .index (arr_idx),
        .wdata (arr_wdata),
        .rdata (Read_Data)
    );

endmodule
